// File: rtl/row_filter_n.sv
// row_filter_n - streaming 1-D row convolution feeding the column stage of the 2-D PE.
//
// Keeps a sliding window of the last TAPS signed samples and a runtime-loadable
// bank of TAPS signed weights. Each beat that completes a window launches one
// result. The result is sum(w[k] * win[k]), where w[0] applies to the newest
// sample. The multiply-accumulate runs through a registered two-stage pipeline:
// stage 1 holds the products and stage 2 holds the sum, with optional
// saturation. The whole path stalls under downstream backpressure.
//
// Ports:
//   clk        clock, all state on the rising edge
//   rst        asynchronous active-low reset
//   in_valid   sample valid
//   in_ready   block can accept a sample
//   in_first   sample is the first pixel of a row (flushes the window)
//   din        signed sample
//   w_wr       weight write strobe (not affected by stalls)
//   w_idx      weight index; indices >= TAPS are ignored
//   w_data     signed weight
//   out_valid  result valid
//   out_ready  downstream accepts the result
//   dout       signed filtered result
//   out_sat    dout was clamped (SAT=1 only)
module row_filter_n #(
   parameter int BITWIDTH = 8,
   parameter int TAPS     = 3,
   parameter int SAT      = 0,
   localparam int OUTW    = 2*BITWIDTH + $clog2(TAPS),
   localparam int IDXW    = (TAPS > 1) ? $clog2(TAPS) : 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic                       in_first,
   input  logic signed [BITWIDTH-1:0] din,
   input  logic                       w_wr,
   input  logic [IDXW-1:0]            w_idx,
   input  logic signed [BITWIDTH-1:0] w_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic signed [OUTW-1:0]     dout,
   output logic                       out_sat
);

   localparam int PW = 2*BITWIDTH;
   localparam int FW = $clog2(TAPS+1);
   // Limits of the signed 2*BITWIDTH range used when clamping.
   localparam logic signed [PW-1:0] PMAX = {1'b0, {(PW-1){1'b1}}};
   localparam logic signed [PW-1:0] PMIN = {1'b1, {(PW-1){1'b0}}};

   // Signed product computed at full 2*BITWIDTH width so that no bits are lost.
   function automatic logic signed [PW-1:0] mul_f(input logic signed [BITWIDTH-1:0] a,
                                                 input logic signed [BITWIDTH-1:0] b);
      logic signed [PW-1:0] ax;
      logic signed [PW-1:0] bx;
      ax = PW'(a);
      bx = PW'(b);
      return ax * bx;
   endfunction

   logic                       alive_q, alive_d;
   logic signed [BITWIDTH-1:0] win_q [TAPS];
   logic signed [BITWIDTH-1:0] win_d [TAPS];
   logic signed [BITWIDTH-1:0] w_q [TAPS];
   logic signed [BITWIDTH-1:0] w_d [TAPS];
   logic [FW-1:0]              fill_q, fill_d;
   logic                       launch_q, launch_d;
   logic                       s1_valid_q, s1_valid_d;
   logic signed [PW-1:0]       prod_q [TAPS];
   logic signed [PW-1:0]       prod_d [TAPS];
   logic                       out_valid_q, out_valid_d;
   logic signed [OUTW-1:0]     dout_q, dout_d;
   logic                       out_sat_q, out_sat_d;
   logic                       stall_s, accept_s;
   logic signed [OUTW-1:0]     sum_s;

   // A held result freezes the entire pipeline. alive_q keeps in_ready low until the first edge after reset.
   always_comb begin
      alive_d  = 1'b1;
      stall_s  = out_valid_q && !out_ready;
      accept_s = in_valid && alive_q && !stall_s;
   end

   assign in_ready  = alive_q && !stall_s;
   assign out_valid = out_valid_q;
   assign dout      = dout_q;
   assign out_sat   = out_sat_q;

   // Window shift, row flush, fill count, and launch of a result when the window becomes full.
   always_comb begin
      for (int k = 0; k < TAPS; k++) win_d[k] = win_q[k];
      fill_d   = fill_q;
      launch_d = launch_q;
      if (!stall_s) begin
         if (accept_s) begin
            win_d[0] = din;
            for (int k = 1; k < TAPS; k++) begin
               win_d[k] = in_first ? {BITWIDTH{1'b0}} : win_q[k-1];
            end
            if (in_first) begin
               fill_d = FW'(1);
            end else if (fill_q != FW'(TAPS)) begin
               fill_d = fill_q + FW'(1);
            end else begin
               fill_d = fill_q;
            end
            launch_d = (fill_d == FW'(TAPS));
         end else begin
            launch_d = 1'b0;
         end
      end else begin
         launch_d = launch_q;
      end
   end

   // Weight bank writes ignore stalls. An out-of-range index matches no entry.
   always_comb begin
      for (int k = 0; k < TAPS; k++) begin
         w_d[k] = (w_wr && (w_idx == IDXW'(k))) ? w_data : w_q[k];
      end
   end

   // Stage 1: capture the per-tap products using the weights present at this edge.
   always_comb begin
      if (stall_s) begin
         s1_valid_d = s1_valid_q;
         for (int k = 0; k < TAPS; k++) prod_d[k] = prod_q[k];
      end else begin
         s1_valid_d = launch_q;
         for (int k = 0; k < TAPS; k++) prod_d[k] = mul_f(w_q[k], win_q[k]);
      end
   end

   // Stage 2: sign-extended sum of the products, with optional clamp to the 2*BITWIDTH range.
   always_comb begin
      sum_s = {OUTW{1'b0}};
      for (int k = 0; k < TAPS; k++) sum_s = sum_s + OUTW'(prod_q[k]);
      out_valid_d = out_valid_q;
      dout_d      = dout_q;
      out_sat_d   = out_sat_q;
      if (!stall_s) begin
         out_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            if ((SAT != 0) && (sum_s > OUTW'(PMAX))) begin
               dout_d    = OUTW'(PMAX);
               out_sat_d = 1'b1;
            end else if ((SAT != 0) && (sum_s < OUTW'(PMIN))) begin
               dout_d    = OUTW'(PMIN);
               out_sat_d = 1'b1;
            end else begin
               dout_d    = sum_s;
               out_sat_d = 1'b0;
            end
         end else begin
            dout_d    = dout_q;
            out_sat_d = out_sat_q;
         end
      end else begin
         out_valid_d = out_valid_q;
      end
   end

   // State registers. Reset clears everything, including any results still in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         alive_q     <= 1'b0;
         fill_q      <= {FW{1'b0}};
         launch_q    <= 1'b0;
         s1_valid_q  <= 1'b0;
         out_valid_q <= 1'b0;
         dout_q      <= {OUTW{1'b0}};
         out_sat_q   <= 1'b0;
         for (int k = 0; k < TAPS; k++) begin
            win_q[k]  <= {BITWIDTH{1'b0}};
            w_q[k]    <= {BITWIDTH{1'b0}};
            prod_q[k] <= {PW{1'b0}};
         end
      end else begin
         alive_q     <= alive_d;
         fill_q      <= fill_d;
         launch_q    <= launch_d;
         s1_valid_q  <= s1_valid_d;
         out_valid_q <= out_valid_d;
         dout_q      <= dout_d;
         out_sat_q   <= out_sat_d;
         for (int k = 0; k < TAPS; k++) begin
            win_q[k]  <= win_d[k];
            w_q[k]    <= w_d[k];
            prod_q[k] <= prod_d[k];
         end
      end
   end

endmodule

// File: doc/row_filter_n.md
Name: row_filter_n

Overview:
Parametrised streaming 1-D row convolution, successor to the fixed 3-tap row filter. It holds an internal sliding window of TAPS signed samples and a runtime-loadable TAPS-entry signed weight bank. Products are summed in a registered two-stage pipeline with ready/valid backpressure, row-start window flush and optional saturation. It feeds the column-accumulation stage of the 2-D PE.

Parameters:
BITWIDTH, 8, signed sample/weight width (>=2)
TAPS, 3, filter length / window depth (>=1)
SAT, 0, 1 = clamp result to signed 2*BITWIDTH range; 0 = full-precision wrap-free result
OUTW, 2*BITWIDTH+clog2(TAPS), derived output width (localparam, not overridable)

Ports:
clk  in  1  clock; all state on rising edge
rst  in  1  asynchronous, active-low reset
in_valid  in  1  sample valid
in_ready  out  1  block can accept sample
in_first  in  1  qualifies in_valid: sample is first pixel of a row
din  in  BITWIDTH  signed sample
w_wr  in  1  weight write strobe
w_idx  in  clog2(TAPS) (min 1)  weight index
w_data  in  BITWIDTH  signed weight
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
dout  out  OUTW  signed filtered result
out_sat  out  1  dout was clamped (SAT=1 only; tied 0 when SAT=0)

Behaviour:
- Reset (rst low, async): window, weights, fill count, pipeline valids, out_valid, dout, out_sat all 0; in_ready 1 one cycle after release. Reset mid-stream drops all in-flight results without emitting them.
- Accept: beat accepted when in_valid && in_ready. in_ready = !(out_valid && !out_ready); stall freezes window, fill count and both pipeline stages.
- Window: on accept, shift; win[0] = din (newest), win[k] = previous win[k-1]. If in_first, win[1..TAPS-1] cleared to 0 and fill count = 1; else fill = min(fill+1, TAPS).
- Tap mapping: result = sum over k of w[k]*win[k] (w[0] applies to newest sample).
- Window-complete: an accepted beat that makes fill == TAPS launches a result; earlier beats of a row launch nothing. TAPS=1: every beat launches.
- Pipeline: stage 1 registers TAPS signed products (2*BITWIDTH each); stage 2 registers the sign-extended adder-tree sum (OUTW) plus saturation. Launch on accept at edge t -> out_valid high after edge t+2 when not stalled. Throughput 1/cycle.
- Saturation (SAT=1): sum > 2^(2B-1)-1 -> that value; sum < -2^(2B-1) -> that value; sign-extended to OUTW; out_sat=1 with that result. SAT=0: full OUTW sum, out_sat=0.
- Output hold: out_valid && !out_ready holds dout/out_sat stable; out_valid drops after acceptance unless a new result is ready the same cycle.
- Weights: w_wr writes w[w_idx] = w_data at edge, independent of stall. Visible to stage-1 products computed on later edges; beats already in stage 1/2 are unaffected. w_idx >= TAPS ignored.
- Simultaneous in_first with window-complete never happens for TAPS>1; for TAPS=1 in_first launches normally.

Test Plan:
- B=8,T=3,SAT=0; weights 1,2,3; row 1,2,3,4 (in_first on 1), out_ready=1 -> exactly two results 10 then 16, first 2 cycles after the sample 3 accept, back-to-back.
- Row flush: after above, in_first with 5, then 6, 7 -> no output for 5, 6; single result 5*3+6*2+7*1=34 on 7; no cross-row mixing with 4.
- Signed/saturation: all weights -128, samples -128 x3: SAT=0 -> dout=49152 (18-bit), out_sat=0; SAT=1 -> dout=32767 sign-extended, out_sat=1; weights 127, samples -128 SAT=1 -> -32768, out_sat=1.
- Backpressure: stream 10 samples with out_ready toggling 1,0,0,1 -> no result lost or duplicated, dout stable while stalled, in_ready low only while out_valid && !out_ready.
- Weight update mid-stream: change w[0] 1->5 between samples 4 and 5 of a constant-1 row -> results 6,6 then 10 for the first product using new weight; in-flight result unaffected.
- Async reset: assert rst low mid-cycle with two results in flight -> out_valid and dout 0 immediately, no result after release; weights read back as 0 (all-zero output on next full row).
